// File: rtl/gba_color_blender.sv
// Purpose: GBA color special effects (alpha, brighten, darken, semi-transparent OBJ) on resolved pixels.
// Latency: 3 register stages; a pixel presented after edge N is captured at N+1 and is valid after N+3.
// Backpressure: every stage advances only when out_valid is low or out_ready is high; in_ready mirrors that.
module gba_color_blender #(
    parameter int LINE_W      = 240,
    parameter int PIPE_STAGES = 3
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        clear,
    input  logic        line_start,
    input  logic [15:0] bldcnt,
    input  logic [15:0] bldalpha,
    input  logic [15:0] bldy,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [14:0] color0,
    input  logic [14:0] color1,
    input  logic [2:0]  top_id,
    input  logic [2:0]  bot_id,
    input  logic        top_semitrans,
    input  logic        sfx_en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [14:0] out_color,
    output logic [7:0]  out_x,
    output logic        out_last
);

    typedef enum logic [1:0] {OP_PASS = 2'd0, OP_ALPHA = 2'd1, OP_BRIGHT = 2'd2, OP_DARK = 2'd3} op_t;

    generate
        if (PIPE_STAGES != 3) begin : g_bad_stages
            $error("gba_color_blender supports only PIPE_STAGES == 3");
        end
    endgenerate

    logic [15:0] sh_cnt, sh_alpha, sh_y;
    logic        adv;
    logic        out_hs;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign out_hs   = out_valid & out_ready;

    // Upper register bits carry no effect meaning on this block.
    logic unused_bits;
    assign unused_bits = ^{sh_cnt[15:14], sh_alpha[15:13], sh_alpha[7:5], sh_y[15:5]};

    function automatic logic [4:0] clamp16(input logic [4:0] v);
        return (v > 5'd16) ? 5'd16 : v;
    endfunction

    // Ids 6 and 7 fall in the zero-extended bits, so they never count as targets.
    function automatic logic is_tgt(input logic [5:0] set, input logic [2:0] id);
        logic [7:0] ext;
        ext = {2'b00, set};
        return ext[id];
    endfunction

    // Shadow copies of the blend registers, refreshed only at line start.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sh_cnt   <= '0;
            sh_alpha <= '0;
            sh_y     <= '0;
        end else if (line_start) begin
            sh_cnt   <= bldcnt;
            sh_alpha <= bldalpha;
            sh_y     <= bldy;
        end
    end

    // ---------------- Stage 1: effect decode ----------------
    op_t        op_d;
    logic [4:0] c0_d, c1_d;

    // Effect select in priority order; the semi-transparent OBJ case bypasses the 1st-target test.
    always_comb begin
        op_d = OP_PASS;
        if (!sfx_en) begin
            op_d = OP_PASS;
        end else if (top_semitrans && is_tgt(sh_cnt[13:8], bot_id)) begin
            op_d = OP_ALPHA;
        end else if (!is_tgt(sh_cnt[5:0], top_id)) begin
            op_d = OP_PASS;
        end else begin
            case (sh_cnt[7:6])
                2'd0:    op_d = OP_PASS;
                2'd1:    op_d = is_tgt(sh_cnt[13:8], bot_id) ? OP_ALPHA : OP_PASS;
                2'd2:    op_d = OP_BRIGHT;
                default: op_d = OP_DARK;
            endcase
        end
        c0_d = (op_d == OP_ALPHA) ? clamp16(sh_alpha[4:0]) : clamp16(sh_y[4:0]);
        c1_d = clamp16(sh_alpha[12:8]);
    end

    logic       s1_vld;
    op_t        s1_op;
    logic [14:0] s1_a, s1_b;
    logic [4:0] s1_c0, s1_c1;

    // Stage 1 register: captures operands and coefficients so later shadow reloads cannot touch this pixel.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            s1_vld <= 1'b0;
            s1_op  <= OP_PASS;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_c0  <= '0;
            s1_c1  <= '0;
        end else if (clear) begin
            s1_vld <= 1'b0;
        end else if (adv) begin
            s1_vld <= in_valid;
            s1_op  <= op_d;
            s1_a   <= color0;
            s1_b   <= color1;
            s1_c0  <= c0_d;
            s1_c1  <= c1_d;
        end
    end

    // ---------------- Stage 2: per-channel multiply ----------------
    logic [2:0][9:0] p0_d, p1_d;
    logic [4:0]      av, bv, mv;

    // p0 = (a or 31-a) * eva/evy, p1 = b * evb; products stay below 512.
    always_comb begin
        p0_d = '0;
        p1_d = '0;
        av   = '0;
        bv   = '0;
        mv   = '0;
        for (int ch = 0; ch < 3; ch++) begin
            av = s1_a[ch*5 +: 5];
            bv = s1_b[ch*5 +: 5];
            mv = (s1_op == OP_BRIGHT) ? (5'd31 - av) : av;
            p0_d[ch] = 10'(mv) * 10'(s1_c0);
            p1_d[ch] = 10'(bv) * 10'(s1_c1);
        end
    end

    logic            s2_vld;
    op_t             s2_op;
    logic [14:0]     s2_a;
    logic [2:0][9:0] s2_p0, s2_p1;

    // Stage 2 register: products travel with the original top color for pass/brighten/darken.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            s2_vld <= 1'b0;
            s2_op  <= OP_PASS;
            s2_a   <= '0;
            s2_p0  <= '0;
            s2_p1  <= '0;
        end else if (clear) begin
            s2_vld <= 1'b0;
        end else if (adv) begin
            s2_vld <= s1_vld;
            s2_op  <= s1_op;
            s2_a   <= s1_a;
            s2_p0  <= p0_d;
            s2_p1  <= p1_d;
        end
    end

    // ---------------- Stage 3: sum, shift, saturate ----------------
    logic [14:0] res_d;
    logic [9:0]  sum;
    logic [5:0]  shv;
    logic [4:0]  ac, dv;

    // Alpha can reach 62 and is saturated; brighten/darken are bounded by construction.
    always_comb begin
        res_d = '0;
        sum   = '0;
        shv   = '0;
        ac    = '0;
        dv    = '0;
        for (int ch = 0; ch < 3; ch++) begin
            ac  = s2_a[ch*5 +: 5];
            sum = s2_p0[ch] + s2_p1[ch];
            shv = 6'(sum >> 4);
            dv  = 5'(s2_p0[ch] >> 4);
            case (s2_op)
                OP_ALPHA:  res_d[ch*5 +: 5] = (shv > 6'd31) ? 5'd31 : shv[4:0];
                OP_BRIGHT: res_d[ch*5 +: 5] = ac + dv;
                OP_DARK:   res_d[ch*5 +: 5] = ac - dv;
                default:   res_d[ch*5 +: 5] = ac;
            endcase
        end
    end

    logic [7:0] x_inc, x_now;
    assign x_inc = (out_x == 8'(LINE_W - 1)) ? 8'd0 : out_x + 8'd1;
    assign x_now = out_hs ? x_inc : out_x;

    // Output register and column counter; out_x advances on each handshake so a held pixel keeps its column.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            out_valid <= 1'b0;
            out_color <= '0;
            out_x     <= '0;
            out_last  <= 1'b0;
        end else if (clear) begin
            out_valid <= 1'b0;
            out_x     <= '0;
            out_last  <= 1'b0;
        end else begin
            if (out_hs) begin
                out_x <= x_inc;
            end
            if (adv) begin
                out_valid <= s2_vld;
                out_color <= res_d;
                out_last  <= s2_vld & (x_now == 8'(LINE_W - 1));
            end
        end
    end

endmodule

// File: tb/tb_gba_color_blender.sv
// Purpose: directed scoreboard bench for gba_color_blender.
// Latency: expected pixels queued at input handshake, popped by a monitor on output handshake.
// Backpressure: out_ready is stalled and toggled to exercise hold and flow control.
module tb_gba_color_blender;

    logic        clk = 1'b0;
    logic        rst_b, clear, line_start;
    logic [15:0] bldcnt, bldalpha, bldy;
    logic        in_valid, in_ready;
    logic [14:0] color0, color1;
    logic [2:0]  top_id, bot_id;
    logic        top_semitrans, sfx_en;
    logic        out_valid, out_ready;
    logic [14:0] out_color;
    logic [7:0]  out_x;
    logic        out_last;

    always #5 clk = ~clk;

    gba_color_blender #(.LINE_W(240), .PIPE_STAGES(3)) dut (
        .clk(clk), .rst_b(rst_b), .clear(clear), .line_start(line_start),
        .bldcnt(bldcnt), .bldalpha(bldalpha), .bldy(bldy),
        .in_valid(in_valid), .in_ready(in_ready),
        .color0(color0), .color1(color1), .top_id(top_id), .bot_id(bot_id),
        .top_semitrans(top_semitrans), .sfx_en(sfx_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_color(out_color), .out_x(out_x), .out_last(out_last)
    );

    typedef struct packed {
        logic [14:0] color;
        logic [7:0]  x;
        logic        last;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   exp_x  = 0;
    bit   tog_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [14:0] c);
        exp_t e;
        e.color = c;
        e.x     = 8'(exp_x);
        e.last  = (exp_x == 239);
        sb.push_back(e);
        exp_x = (exp_x == 239) ? 0 : exp_x + 1;
    endtask

    // Monitor: pops the scoreboard on each output handshake and checks hold stability while stalled.
    bit          prev_hold = 1'b0;
    logic [14:0] hold_c;
    logic [7:0]  hold_x;
    logic        hold_l;
    always @(negedge clk) begin
        if (!rst_b) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_color", 32'(out_color), 32'(hold_c));
                chk("hold_x", 32'(out_x), 32'(hold_x));
                chk("hold_last", 32'(out_last), 32'(hold_l));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got color 0x%0h x %0d, expected no pixel", out_color, out_x);
                end else begin
                    mon_e = sb.pop_front();
                    chk("out_color", 32'(out_color), 32'(mon_e.color));
                    chk("out_x", 32'(out_x), 32'(mon_e.x));
                    chk("out_last", 32'(out_last), 32'(mon_e.last));
                end
            end
            prev_hold = out_valid && !out_ready && !clear;
            hold_c    = out_color;
            hold_x    = out_x;
            hold_l    = out_last;
        end
    end

    // out_ready toggler for the backpressure stream.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tog_en) out_ready = ~out_ready;
        end
    end

    task automatic load(input logic [15:0] cnt, input logic [15:0] al, input logic [15:0] y);
        bldcnt     = cnt;
        bldalpha   = al;
        bldy       = y;
        line_start = 1'b1;
        @(posedge clk);
        #1;
        line_start = 1'b0;
    endtask

    task automatic send(input logic [14:0] c0, input logic [14:0] c1, input logic [2:0] tid,
                        input logic [2:0] bid, input logic semi, input logic sfx,
                        input logic ls, input logic [14:0] expc);
        bit hs;
        hs            = 1'b0;
        color0        = c0;
        color1        = c1;
        top_id        = tid;
        bot_id        = bid;
        top_semitrans = semi;
        sfx_en        = sfx;
        line_start    = ls;
        in_valid      = 1'b1;
        for (int i = 0; i < 200 && !hs; i++) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            line_start = 1'b0;
        end
        in_valid = 1'b0;
        if (hs) begin
            push(expc);
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no in_ready within 200 cycles, expected acceptance");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 1000 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pixels outstanding, expected 0", sb.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_b = 1'b0; clear = 1'b0; line_start = 1'b0;
        bldcnt = '0; bldalpha = '0; bldy = '0;
        in_valid = 1'b0; color0 = '0; color1 = '0;
        top_id = '0; bot_id = '0; top_semitrans = 1'b0; sfx_en = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_color", 32'(out_color), 32'd0);
        chk("rst_out_x", 32'(out_x), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_b = 1'b1;

        // Alpha blend, BG0 over BG0, eva=evb=8, with latency check.
        load(16'h0141, 16'h0808, 16'h0000);
        send(15'h001F, 15'h7C00, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 15'h3C0F);
        @(negedge clk);
        chk("lat_stage1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_stage2", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_stage3", 32'(out_valid), 32'd1);
        drain();

        // Brighten with evy=16 and evy=20 (clamped).
        load(16'h0081, 16'h0000, 16'd16);
        send(15'h0000, 15'h0000, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 15'h7FFF);
        load(16'h0081, 16'h0000, 16'd20);
        send(15'h0000, 15'h0000, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 15'h7FFF);

        // Darken evy=8, then the same pixel with the window effect disabled.
        load(16'h00C1, 16'h0000, 16'd8);
        send(15'h7FFF, 15'h0000, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 15'h4210);
        send(15'h7FFF, 15'h0000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 15'h7FFF);

        // Semi-transparent OBJ forces saturating alpha; opaque OBJ (not a 1st target) passes.
        load(16'h1F00, 16'h1010, 16'h0000);
        send(15'h7FFF, 15'h7FFF, 3'd4, 3'd0, 1'b1, 1'b1, 1'b0, 15'h7FFF);
        send(15'h1234, 15'h7FFF, 3'd4, 3'd0, 1'b0, 1'b1, 1'b0, 15'h1234);
        drain();

        // Shadow reload mid-stream: the pixel accepted on the line_start edge keeps evy=8.
        load(16'h00C1, 16'h0000, 16'd8);
        send(15'h7FFF, 15'h0000, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 15'h4210);
        bldy = 16'd16;
        send(15'h7FFF, 15'h0000, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 15'h4210);
        send(15'h7FFF, 15'h0000, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 15'h0000);
        send(15'h7FFF, 15'h0000, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 15'h0000);
        drain();

        // Clear with a stalled, full pipeline: pixels dropped, column restarts.
        out_ready = 1'b0;
        send(15'h0111, 15'h0000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 15'h0111);
        send(15'h0222, 15'h0000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 15'h0222);
        send(15'h0333, 15'h0000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 15'h0333);
        @(negedge clk);
        chk("full_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        sb.delete();
        exp_x = 0;
        chk("clear_valid", 32'(out_valid), 32'd0);
        chk("clear_x", 32'(out_x), 32'd0);
        out_ready = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        chk("clear_no_output", 32'(out_valid), 32'd0);

        // Full line with out_ready toggling, then one pixel into the next line.
        tog_en = 1'b1;
        for (int i = 0; i < 240; i++) begin
            send(15'(i * 131), 15'h0000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 15'(i * 131));
        end
        send(15'h5555, 15'h0000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 15'h5555);
        drain();
        tog_en = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Asynchronous reset with pixels in flight.
        out_ready = 1'b0;
        send(15'h0444, 15'h0000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 15'h0444);
        send(15'h0555, 15'h0000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 15'h0555);
        send(15'h0666, 15'h0000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 15'h0666);
        #2;
        rst_b = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_x", 32'(out_x), 32'd0);
        sb.delete();
        exp_x = 0;
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        // Shadows are zero after reset: BG0 is no target, so the pixel passes at column 0.
        send(15'h0ABC, 15'h7FFF, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 15'h0ABC);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
